// File: rtl/ctrl_oven_multi.sv
// Microwave oven controller with N power levels, N time presets and an integrated cook countdown.
// Optional add-time button is enabled by defining CTRL_OVEN_ADD_TIME_EN.
module ctrl_oven_multi #(
    parameter int N_POWER  = 4,
    parameter int N_PRESET = 3,
    parameter int BASE_SEC = 30,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 1,
    localparam int PL_W    = (N_POWER > 1) ? $clog2(N_POWER) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_POWER-1:0]  power_sel,
    input  logic [N_PRESET-1:0] time_sel,
    input  logic                time_set,
    input  logic                start,
    input  logic                door_open,
    input  logic                cancel,
`ifdef CTRL_OVEN_ADD_TIME_EN
    input  logic                add_time,
`endif
    output logic [PL_W-1:0]     power_level,
    output logic                power_valid,
    output logic                heating,
    output logic                in_light,
    output logic                finished,
    output logic [CNT_W-1:0]    remaining
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle, StPowerSet, StOpEnabled, StOpDisabled, StOperating, StPaused, StComplete
    } state_e;

    state_e             r_state, w_state_d;
    logic [PL_W-1:0]    r_level, w_level_d;
    logic               r_valid, w_valid_d;
    logic [CNT_W-1:0]   r_rem, w_rem_d;
    logic [PRE_W-1:0]   r_pre, w_pre_d;
    logic               r_heating, r_in_light, r_finished;
    logic [PL_W-1:0]    w_pwr_idx;
    logic [CNT_W-1:0]   w_preset;
    logic               w_pwr_ok, w_time_ok;

    assign w_pwr_ok  = $onehot(power_sel);
    assign w_time_ok = $onehot(time_sel);

    always_comb begin
        w_pwr_idx = '0;
        for (int i = 0; i < N_POWER; i++) begin
            if (power_sel[i]) w_pwr_idx = PL_W'(i);
        end
    end

    always_comb begin
        w_preset = '0;
        for (int k = 0; k < N_PRESET; k++) begin
            if (time_sel[k]) w_preset = CNT_W'(BASE_SEC << k);
        end
    end

`ifdef CTRL_OVEN_ADD_TIME_EN
    logic             r_add_prev;
    logic             w_add_edge;
    logic [CNT_W:0]   w_sum;

    assign w_add_edge = add_time & ~r_add_prev;

    always_ff @(posedge clk) begin
        if (!reset) r_add_prev <= 1'b0;
        else        r_add_prev <= add_time;
    end
`endif

    always_comb begin
        w_state_d = r_state;
        w_level_d = r_level;
        w_valid_d = r_valid;
        w_rem_d   = r_rem;
        w_pre_d   = r_pre;
`ifdef CTRL_OVEN_ADD_TIME_EN
        w_sum     = '0;
`endif
        if (cancel && r_state != StIdle) begin
            w_state_d = StIdle;
            w_level_d = '0;
            w_valid_d = 1'b0;
            w_rem_d   = '0;
            w_pre_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pwr_ok) begin
                        w_state_d = StPowerSet;
                        w_level_d = w_pwr_idx;
                        w_valid_d = 1'b1;
                    end
                end
                StPowerSet: begin
                    if (w_pwr_ok) w_level_d = w_pwr_idx;
                    if (time_set && w_time_ok) begin
                        w_rem_d   = w_preset;
                        w_state_d = door_open ? StOpDisabled : StOpEnabled;
                    end
                end
                StOpEnabled: begin
                    if (door_open) begin
                        w_state_d = StOpDisabled;
                    end else if (start) begin
                        w_state_d = StOperating;
                        w_pre_d   = '0;
                    end
                end
                StOpDisabled: begin
                    if (!door_open) w_state_d = StOpEnabled;
                end
                StOperating: begin
                    // Door has priority over a coincident tick: nothing advances.
                    if (door_open) begin
                        w_state_d = StPaused;
                    end else if (r_rem == '0) begin
                        w_state_d = StComplete;
                    end else if (r_pre == PRE_MAX) begin
                        w_pre_d = '0;
                        w_rem_d = r_rem - 1'b1;
                        if (r_rem == CNT_W'(1)) w_state_d = StComplete;
                    end else begin
                        w_pre_d = r_pre + 1'b1;
                    end
                end
                StPaused: begin
                    if (!door_open && start) w_state_d = StOperating;
                end
                StComplete: begin
                    if (door_open) begin
                        w_state_d = StIdle;
                        w_level_d = '0;
                        w_valid_d = 1'b0;
                        w_rem_d   = '0;
                        w_pre_d   = '0;
                    end
                end
                default: w_state_d = StIdle;
            endcase
`ifdef CTRL_OVEN_ADD_TIME_EN
            if (w_add_edge && (r_state == StOperating || r_state == StPaused)) begin
                // An add landing on the final decrement revives the cook instead of finishing.
                if (w_state_d == StComplete) begin
                    w_rem_d   = CNT_W'(BASE_SEC);
                    w_state_d = StOperating;
                end else begin
                    w_sum   = {1'b0, w_rem_d} + (CNT_W + 1)'(BASE_SEC);
                    w_rem_d = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_rem      <= '0;
            r_pre      <= '0;
            r_heating  <= 1'b0;
            r_in_light <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_level    <= w_level_d;
            r_valid    <= w_valid_d;
            r_rem      <= w_rem_d;
            r_pre      <= w_pre_d;
            r_heating  <= (w_state_d == StOperating);
            r_in_light <= (w_state_d == StOperating) || (w_state_d == StPaused) ||
                          (w_state_d == StOpDisabled);
            r_finished <= (w_state_d == StComplete);
        end
    end

    assign power_level = r_level;
    assign power_valid = r_valid;
    assign heating     = r_heating;
    assign in_light    = r_in_light;
    assign finished    = r_finished;
    assign remaining   = r_rem;

endmodule

// File: tb/tb_ctrl_oven_multi.sv
// Directed self-checking bench for ctrl_oven_multi (TICK_DIV=2, other parameters default).
module tb_ctrl_oven_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] power_sel;
    logic [2:0] time_sel;
    logic       time_set;
    logic       start;
    logic       door_open;
    logic       cancel;
`ifdef CTRL_OVEN_ADD_TIME_EN
    logic       add_time;
`endif
    logic [1:0] power_level;
    logic       power_valid;
    logic       heating;
    logic       in_light;
    logic       finished;
    logic [7:0] remaining;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_oven_multi #(
        .N_POWER  (4),
        .N_PRESET (3),
        .BASE_SEC (30),
        .CNT_W    (8),
        .TICK_DIV (2)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .power_sel   (power_sel),
        .time_sel    (time_sel),
        .time_set    (time_set),
        .start       (start),
        .door_open   (door_open),
        .cancel      (cancel),
`ifdef CTRL_OVEN_ADD_TIME_EN
        .add_time    (add_time),
`endif
        .power_level (power_level),
        .power_valid (power_valid),
        .heating     (heating),
        .in_light    (in_light),
        .finished    (finished),
        .remaining   (remaining)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        power_sel = '0;
        time_sel  = '0;
        time_set  = 1'b0;
        start     = 1'b0;
        door_open = 1'b0;
        cancel    = 1'b0;
`ifdef CTRL_OVEN_ADD_TIME_EN
        add_time  = 1'b0;
`endif
        tick();
        reset = 1'b1;
    endtask

    // Select power level, commit preset with door closed, start; returns one cycle into OPERATING.
    task automatic begin_cook(input logic [3:0] pw, input logic [2:0] ts);
        power_sel = pw;
        tick();
        power_sel = '0;
        time_sel  = ts;
        time_set  = 1'b1;
        tick();
        time_set  = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", power_valid, 0);
        check("rst_level", power_level, 0);
        check("rst_heat", heating, 0);
        check("rst_light", in_light, 0);
        check("rst_fin", finished, 0);
        check("rst_rem", remaining, 0);

        // Basic cook
        power_sel = 4'b0100;
        tick();
        check("basic_valid", power_valid, 1);
        check("basic_level", power_level, 2);
        power_sel = '0;
        time_sel  = 3'b001;
        time_set  = 1'b1;
        tick();
        time_set  = 1'b0;
        check("basic_rem_load", remaining, 30);
        check("basic_light_en", in_light, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_heat", heating, 1);
        check("basic_light", in_light, 1);
        check("basic_rem_e0", remaining, 30);
        tick();
        check("basic_rem_e1", remaining, 30);
        tick();
        check("basic_rem_e2", remaining, 29);
        tick(57);
        check("basic_fin_e59", finished, 0);
        check("basic_rem_e59", remaining, 1);
        tick();
        check("basic_fin_e60", finished, 1);
        check("basic_rem_e60", remaining, 0);
        check("basic_heat_e60", heating, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_start_ign", finished, 1);
        door_open = 1'b1;
        tick();
        check("basic_door_fin", finished, 0);
        check("basic_door_valid", power_valid, 0);
        check("basic_door_level", power_level, 0);
        check("basic_door_light", in_light, 0);
        door_open = 1'b0;

        // Door open before start
        do_reset();
        power_sel = 4'b0001;
        tick();
        power_sel = '0;
        door_open = 1'b1;
        time_sel  = 3'b010;
        time_set  = 1'b1;
        tick();
        time_set  = 1'b0;
        check("door_rem", remaining, 60);
        check("door_light", in_light, 1);
        check("door_heat", heating, 0);
        start = 1'b1;
        tick(3);
        check("door_nocook", heating, 0);
        check("door_rem_hold", remaining, 60);
        door_open = 1'b0;
        tick();
        check("door_closed_light", in_light, 0);
        check("door_closed_heat", heating, 0);
        tick();
        check("door_start_heat", heating, 1);
        check("door_level", power_level, 0);
        start = 1'b0;

        // Pause and resume
        do_reset();
        begin_cook(4'b1000, 3'b100);
        check("pause_level", power_level, 3);
        check("pause_rem0", remaining, 120);
        tick(10);
        check("pause_rem10", remaining, 115);
        door_open = 1'b1;
        tick();
        check("pause_heat", heating, 0);
        check("pause_light", in_light, 1);
        tick(6);
        check("pause_rem_hold", remaining, 115);
        door_open = 1'b0;
        tick();
        check("pause_nostart", heating, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("resume_heat", heating, 1);
        tick(229);
        check("resume_fin229", finished, 0);
        check("resume_rem229", remaining, 1);
        tick();
        check("resume_fin230", finished, 1);

        // Invalid selections and re-latch
        do_reset();
        power_sel = 4'b0110;
        tick();
        check("inv_pwr_valid", power_valid, 0);
        power_sel = 4'b0010;
        tick();
        check("inv_pwr_ok", power_valid, 1);
        check("inv_pwr_level", power_level, 1);
        power_sel = '0;
        time_sel  = 3'b011;
        time_set  = 1'b1;
        tick();
        time_set  = 1'b0;
        check("inv_time_rem", remaining, 0);
        check("inv_time_valid", power_valid, 1);
        power_sel = 4'b0100;
        tick();
        power_sel = '0;
        check("relatch_level", power_level, 2);
        time_sel = 3'b001;
        time_set = 1'b1;
        tick();
        time_set = 1'b0;
        check("relatch_rem", remaining, 30);

        // Cancel mid-cook at remaining 50
        do_reset();
        begin_cook(4'b0010, 3'b010);
        tick(20);
        check("cancel_rem50", remaining, 50);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_rem", remaining, 0);
        check("cancel_valid", power_valid, 0);
        check("cancel_heat", heating, 0);
        check("cancel_level", power_level, 0);

        // Reset mid-cook at remaining 50
        do_reset();
        begin_cook(4'b0010, 3'b010);
        tick(20);
        check("rstmid_rem50", remaining, 50);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rstmid_rem", remaining, 0);
        check("rstmid_valid", power_valid, 0);
        check("rstmid_heat", heating, 0);

        // Cancel beats coincident door open
        do_reset();
        begin_cook(4'b0010, 3'b010);
        tick(4);
        door_open = 1'b1;
        cancel    = 1'b1;
        tick();
        cancel    = 1'b0;
        check("cdoor_light", in_light, 0);
        check("cdoor_valid", power_valid, 0);
        check("cdoor_rem", remaining, 0);
        door_open = 1'b0;
        power_sel = 4'b0001;
        tick();
        power_sel = '0;
        check("cdoor_idle", power_valid, 1);

`ifdef CTRL_OVEN_ADD_TIME_EN
        // Add time: ordinary add, add on final tick, held input
        do_reset();
        begin_cook(4'b0100, 3'b001);
        tick(50);
        check("add_rem5", remaining, 5);
        add_time = 1'b1;
        tick();
        add_time = 1'b0;
        check("add_rem35", remaining, 35);
        tick(68);
        check("add_rem1", remaining, 1);
        add_time = 1'b1;
        tick();
        add_time = 1'b0;
        check("add_final_rem", remaining, 30);
        check("add_final_fin", finished, 0);
        check("add_final_heat", heating, 1);
        tick(2);
        check("add_pre_hold", remaining, 29);
        add_time = 1'b1;
        tick(10);
        add_time = 1'b0;
        check("add_hold_rem", remaining, 54);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
